// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control slice.
//   ctrl_state_t : sequencing state of the hazard controller.
//   REG_ZERO     : architectural zero register; never a real dependency.
//   stage_ctrl_t : {stall, flush} pair consumed by each pipeline-register wrapper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MDU_BUSY = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator.
// Ports:
//   rs1_d, rs2_d           : source registers of the Decode instruction
//   rs1_used_d, rs2_used_d : Decode instruction actually reads that source
//   rd_e, mem_read_e       : destination / is-load of the Execute instruction
//   load_use               : Decode needs a value the Execute load has not produced yet
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       rs1_used_d,
  input  logic       rs2_used_d,
  input  logic [4:0] rd_e,
  input  logic       mem_read_e,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used_d & (rs1_d == rd_e);
  assign rs2_hit  = rs2_used_d & (rs2_d == rd_e);
  // x0 always reads as zero, so a load targeting it creates no dependency.
  assign load_use = mem_read_e & (rd_e != REG_ZERO) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   rs1_d/rs2_d/rs1_used_d/rs2_used_d, rd_e/mem_read_e : load-use inputs
//   redirect_e                    : taken branch/jump resolved in Execute
//   mdu_start_e, mdu_done         : multi-cycle MDU op in Execute / result pulse
//   imem_ready                    : fetch returned this cycle
//   dmem_req_m, dmem_ready_m      : data-memory handshake in Memory
//   stall_f/d/e/m                 : hold PC, FE_DE, DE_EX, EX_MEM
//   flush_d/e/m/w                 : clear FE_DE, bubble DE_EX, EX_MEM, MEM_WB
//   wait_timeout                  : sticky watchdog flag
//   state_dbg                     : current sequencing state (observation only)
//
// Data-memory handshake: an access is outstanding while dmem_req_m is high and
// completes in the cycle dmem_ready_m is also high; every cycle with
// dmem_req_m & ~dmem_ready_m is a memory wait and freezes the whole pipe.
//
// All outputs are combinational from registered state plus inputs, so every
// hazard is answered in the cycle it appears.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        rs1_used_d,
  input  logic        rs2_used_d,
  input  logic [4:0]  rd_e,
  input  logic        mem_read_e,
  input  logic        redirect_e,
  input  logic        mdu_start_e,
  input  logic        mdu_done,
  input  logic        imem_ready,
  input  logic        dmem_req_m,
  input  logic        dmem_ready_m,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        flush_w,
  output logic        wait_timeout,
  output ctrl_state_t state_dbg
);

  localparam int              WW           = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_MAX     = WW'(MAX_WAIT);
  localparam logic [2:0]      FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  ctrl_state_t   state_q, state_d;
  logic [2:0]    redir_cnt_q, redir_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          done_seen_q, done_seen_d;
  logic          timeout_q;

  logic          mw;
  logic          load_use;
  logic          wait_active;
  stage_ctrl_t   ctrl_d, ctrl_e, ctrl_m;

  assign mw = dmem_req_m & ~dmem_ready_m;

  hazard_detect u_hazard_detect (
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_used_d (rs1_used_d),
    .rs2_used_d (rs2_used_d),
    .rd_e       (rd_e),
    .mem_read_e (mem_read_e),
    .load_use   (load_use)
  );

  // Next-state and outputs. Branch order is the priority order:
  // reset > memory wait > MDU busy > redirect > MDU start > load-use > fetch wait.
  always_comb begin
    state_d     = state_q;
    redir_cnt_d = redir_cnt_q;
    done_seen_d = done_seen_q;
    stall_f     = 1'b0;
    ctrl_d      = '0;
    ctrl_e      = '0;
    ctrl_m      = '0;
    flush_w     = 1'b0;

    if (!reset_n) begin
      ctrl_d.flush = 1'b1;
      ctrl_e.flush = 1'b1;
      ctrl_m.flush = 1'b1;
      flush_w      = 1'b1;
    end else if (mw) begin
      // Freeze everything up to MEM; state and redirect counter hold.
      stall_f      = 1'b1;
      ctrl_d.stall = 1'b1;
      ctrl_e.stall = 1'b1;
      ctrl_m.stall = 1'b1;
      flush_w      = 1'b1;
      // A result arriving while frozen must not be lost.
      if ((state_q == MDU_BUSY) && mdu_done) done_seen_d = 1'b1;
    end else if (state_q == MDU_BUSY) begin
      if (mdu_done | done_seen_q) begin
        // Release cycle: the MDU op advances; only a fetch wait can still hold IF.
        state_d     = RUN;
        done_seen_d = 1'b0;
        if (!imem_ready) begin
          stall_f      = 1'b1;
          ctrl_d.flush = 1'b1;
        end
      end else begin
        stall_f      = 1'b1;
        ctrl_d.stall = 1'b1;
        ctrl_e.stall = 1'b1;
        ctrl_m.flush = 1'b1;
      end
    end else if (redirect_e) begin
      // Wrong-path instructions in FE_DE/DE_EX are discarded; load-use is moot.
      ctrl_d.flush = 1'b1;
      ctrl_e.flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d     = REDIRECT;
        redir_cnt_d = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else if ((state_q == RUN) && mdu_start_e) begin
      state_d      = MDU_BUSY;
      stall_f      = 1'b1;
      ctrl_d.stall = 1'b1;
      ctrl_e.stall = 1'b1;
      ctrl_m.flush = 1'b1;
    end else begin
      if (state_q == REDIRECT) begin
        // Keep discarding fetches that were already in flight at the redirect.
        ctrl_d.flush = 1'b1;
        redir_cnt_d  = redir_cnt_q - 3'd1;
        if (redir_cnt_q == 3'd1) state_d = RUN;
      end
      if (load_use) begin
        stall_f      = 1'b1;
        ctrl_d.stall = 1'b1;
        ctrl_e.flush = 1'b1;
      end else if (!imem_ready) begin
        stall_f      = 1'b1;
        ctrl_d.flush = 1'b1;
      end
    end
  end

  // Watchdog: consecutive frozen cycles, saturating.
  assign wait_active = mw | (state_q == MDU_BUSY);

  always_comb begin
    wait_cnt_d = '0;
    if (wait_active) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      redir_cnt_q <= '0;
      wait_cnt_q  <= '0;
      done_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      redir_cnt_q <= redir_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      done_seen_q <= done_seen_d;
      // Raised together with the count reaching its limit; sticky until reset.
      timeout_q   <= timeout_q | (wait_cnt_d == WAIT_MAX);
    end
  end

  assign stall_d      = ctrl_d.stall;
  assign flush_d      = ctrl_d.flush;
  assign stall_e      = ctrl_e.stall;
  assign flush_e      = ctrl_e.flush;
  assign stall_m      = ctrl_m.stall;
  assign flush_m      = ctrl_m.flush;
  assign wait_timeout = timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=3, MAX_WAIT=4).
// Output vector order: {stall_f, stall_d, stall_e, stall_m,
//                       flush_d, flush_e, flush_m, flush_w, wait_timeout}
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rs1_d, rs2_d, rd_e;
  logic        rs1_used_d, rs2_used_d, mem_read_e;
  logic        redirect_e, mdu_start_e, mdu_done, imem_ready;
  logic        dmem_req_m, dmem_ready_m;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w, wait_timeout;
  ctrl_state_t state_dbg;

  localparam logic [8:0] SF  = 9'h100;
  localparam logic [8:0] SD  = 9'h080;
  localparam logic [8:0] SE  = 9'h040;
  localparam logic [8:0] SM  = 9'h020;
  localparam logic [8:0] FD  = 9'h010;
  localparam logic [8:0] FE  = 9'h008;
  localparam logic [8:0] FM  = 9'h004;
  localparam logic [8:0] FW  = 9'h002;
  localparam logic [8:0] TO  = 9'h001;
  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] MWO = SF | SD | SE | SM | FW;
  localparam logic [8:0] MDU = SF | SD | SE | FM;
  localparam logic [8:0] RST = FD | FE | FM | FW;

  logic [8:0] exp_q[$];
  int checks;
  int errors;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (3),
    .MAX_WAIT     (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_used_d   (rs1_used_d),
    .rs2_used_d   (rs2_used_d),
    .rd_e         (rd_e),
    .mem_read_e   (mem_read_e),
    .redirect_e   (redirect_e),
    .mdu_start_e  (mdu_start_e),
    .mdu_done     (mdu_done),
    .imem_ready   (imem_ready),
    .dmem_req_m   (dmem_req_m),
    .dmem_ready_m (dmem_ready_m),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_m      (flush_m),
    .flush_w      (flush_w),
    .wait_timeout (wait_timeout),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    rs1_d        = 5'd0;
    rs2_d        = 5'd0;
    rd_e         = 5'd0;
    rs1_used_d   = 1'b0;
    rs2_used_d   = 1'b0;
    mem_read_e   = 1'b0;
    redirect_e   = 1'b0;
    mdu_start_e  = 1'b0;
    mdu_done     = 1'b0;
    imem_ready   = 1'b1;
    dmem_req_m   = 1'b0;
    dmem_ready_m = 1'b0;
  endtask

  // Inputs are already driven; queue the expectation, sample mid-cycle,
  // compare, then move to 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    logic [8:0] want;
    exp_q.push_back(exp);
    #2;
    got  = {stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, flush_m, flush_w, wait_timeout};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle_inputs();
    dmem_req_m = 1'b1;  // reset outputs must win over a memory wait
    #1;
    step("reset", RST);
    step("reset_hold", RST);
    reset_n = 1'b1;
    idle_inputs();
    step("idle", NONE);

    // Load-use on rs1, resolves after one cycle
    mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs1_used_d = 1'b1;
    step("lu_rs1", SF | SD | FE);
    mem_read_e = 1'b0;
    step("lu_resolved", NONE);
    mem_read_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0;
    step("lu_x0", NONE);
    rd_e = 5'd7; rs1_d = 5'd3; rs2_d = 5'd7; rs2_used_d = 1'b1;
    step("lu_rs2", SF | SD | FE);
    rs2_used_d = 1'b0;
    step("lu_rs2_unused", NONE);

    // Fetch wait
    idle_inputs();
    imem_ready = 1'b0;
    step("fetch_wait", SF | FD);
    imem_ready = 1'b1;

    // Redirect: flush_d for 3 cycles
    redirect_e = 1'b1; step("redir_c0", FD | FE);
    redirect_e = 1'b0; step("redir_c1", FD);
    step("redir_c2", FD);
    step("redir_end", NONE);

    // Second redirect while in REDIRECT reloads the counter
    redirect_e = 1'b1; step("redir2_c0", FD | FE);
    redirect_e = 1'b0; step("redir2_c1", FD);
    redirect_e = 1'b1; step("redir2_reload", FD | FE);
    redirect_e = 1'b0; step("redir2_r1", FD);
    step("redir2_r2", FD);
    step("redir2_end", NONE);

    // Redirect beats load-use; load-use still honoured during REDIRECT
    redirect_e = 1'b1; mem_read_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd9; rs1_used_d = 1'b1;
    step("prio_redir_lu", FD | FE);
    redirect_e = 1'b0;
    step("redirect_lu", SF | SD | FD | FE);
    idle_inputs();
    step("prio_r2", FD);
    step("prio_end", NONE);

    // Redirect held during memory wait appears when the wait drops
    dmem_req_m = 1'b1; redirect_e = 1'b1;
    step("mw_redir_0", MWO);
    step("mw_redir_1", MWO);
    dmem_ready_m = 1'b1;
    step("mw_redir_go", FD | FE);
    idle_inputs();
    step("mw_redir_c1", FD);
    step("mw_redir_c2", FD);
    step("mw_redir_end", NONE);

    // MDU: stalled cycles 0..10, released on mdu_done; watchdog trips on the way
    mdu_start_e = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      step($sformatf("mdu_c%0d", i), MDU | ((i >= 5) ? TO : NONE));
    end
    mdu_done = 1'b1;
    step("mdu_release", TO);
    idle_inputs();
    step("mdu_after", TO);

    // Reset mid-MDU aborts to RUN and clears the watchdog
    mdu_start_e = 1'b1;
    step("mdu2_c0", MDU | TO);
    step("mdu2_c1", MDU | TO);
    reset_n = 1'b0;
    step("reset_mid_mdu", RST);
    reset_n = 1'b1;
    idle_inputs();
    step("after_mdu_reset", NONE);

    // MDU done during memory wait is remembered
    mdu_start_e = 1'b1;
    step("ovl_c0", MDU);
    mdu_done = 1'b1; dmem_req_m = 1'b1; dmem_ready_m = 1'b0;
    step("ovl_done_in_mw", MWO);
    mdu_done = 1'b0; dmem_ready_m = 1'b1;
    step("ovl_release", NONE);
    dmem_req_m = 1'b0; dmem_ready_m = 1'b0;
    step("ovl_new_mdu", MDU);
    step("ovl_no_stale_done", MDU);
    mdu_done = 1'b1;
    step("ovl_new_release", NONE);
    idle_inputs();
    step("ovl_idle", NONE);

    // Watchdog: mw held 6 cycles, flag rises at cycle 4 and sticks
    dmem_req_m = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step($sformatf("wd_c%0d", i), MWO | ((i >= 4) ? TO : NONE));
    end
    idle_inputs();
    step("wd_sticky0", TO);
    step("wd_sticky1", TO);

    // Reset mid-stall clears everything at once
    dmem_req_m = 1'b1;
    step("wd_stall", MWO | TO);
    reset_n = 1'b0;
    step("reset_mid_stall", RST);
    reset_n = 1'b1;
    idle_inputs();
    step("after_reset", NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Drives the hold and flush inputs of the FE_DE, DE_EX, EX_MEM and MEM_WB pipeline registers and the PC hold.
- Resolves load-use hazards, branch redirects, instruction-fetch wait, data-memory wait and multi-cycle MDU operations.
- Tracks each condition with a small state machine, a redirect counter and a wait watchdog.

Parameters:
- FLUSH_CYCLES, 1: cycles flush_d stays asserted after a redirect, to discard in-flight fetches. Legal range 1..7.
- MAX_WAIT, 255: consecutive stall cycles in MEM_WAIT/MDU_BUSY before wait_timeout sets.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_d  in  5  rs1 of the instruction in Decode.
- rs2_d  in  5  rs2 of the instruction in Decode.
- rs1_used_d  in  1  Decode instruction reads rs1.
- rs2_used_d  in  1  Decode instruction reads rs2.
- rd_e  in  5  destination register of the instruction in Execute.
- mem_read_e  in  1  Execute instruction is a load.
- redirect_e  in  1  taken branch or jump resolved in Execute.
- mdu_start_e  in  1  Execute instruction is a multi-cycle MUL/DIV.
- mdu_done  in  1  one-cycle pulse: MDU result valid.
- imem_ready  in  1  instruction memory returned the fetch this cycle.
- dmem_req_m  in  1  Memory stage has an access outstanding.
- dmem_ready_m  in  1  data memory completes this cycle.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold FE_DE.
- stall_e  out  1  hold DE_EX.
- stall_m  out  1  hold EX_MEM.
- flush_d  out  1  clear FE_DE (pipe_flush).
- flush_e  out  1  insert bubble into DE_EX.
- flush_m  out  1  insert bubble into EX_MEM.
- flush_w  out  1  insert bubble into MEM_WB.
- wait_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset_n low, immediate): state=RUN, redirect counter=0, wait_cnt=0, done_seen=0, wait_timeout=0. While reset_n is low: flush_d=flush_e=flush_m=flush_w=1 and all stalls=0.
- Outputs are combinational from state plus inputs, giving 0-cycle response. All state is registered.
- States: RUN, REDIRECT, MDU_BUSY. The memory-wait condition mw = dmem_req_m & ~dmem_ready_m is an override evaluated in every state, not a separate state.
- Priority, highest first: mw > MDU_BUSY > redirect_e > load-use > fetch wait.
- mw: stall_f/d/e/m=1, flush_w=1, all other flushes 0, state unchanged. The redirect counter does not decrement; wait_cnt increments.
- MDU entry: RUN & mdu_start_e & ~mw -> MDU_BUSY on the next edge; stall_f/d/e=1 and flush_m=1 from that same cycle.
- MDU_BUSY: stall_f/d/e=1, flush_m=1.
  - If mdu_done arrives during mw, set done_seen.
  - Exit to RUN on the first cycle with (mdu_done | done_seen) & ~mw. That cycle drops the stalls and clears done_seen.
- Redirect: redirect_e & ~mw & state!=MDU_BUSY -> flush_d=1, flush_e=1, no stalls; load-use is ignored.
  - If FLUSH_CYCLES>1: go to REDIRECT with counter=FLUSH_CYCLES-1.
  - REDIRECT: flush_d=1 and decrement the counter; at 0 return to RUN.
  - A new redirect_e while in REDIRECT reloads the counter.
- Load-use: mem_read_e & rd_e!=0 & ((rs1_used_d & rs1_d==rd_e) | (rs2_used_d & rs2_d==rd_e)), in RUN/REDIRECT with no higher-priority condition.
  - Response: stall_f=1, stall_d=1, flush_e=1 for exactly one cycle, which resolves naturally as the load advances.
  - No stall when rd_e=0.
- Fetch wait: ~imem_ready with no other condition -> stall_f=1, flush_d=1.
- Watchdog:
  - wait_cnt counts consecutive cycles with mw or state==MDU_BUSY, saturating at MAX_WAIT. Width $clog2(MAX_WAIT+1).
  - The count clears when neither condition holds.
  - wait_timeout sets when wait_cnt reaches MAX_WAIT and is cleared only by reset.
- A reset assertion mid-MDU or mid-redirect aborts immediately to RUN.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - ctrl_state_t enum (RUN, REDIRECT, MDU_BUSY).
  - REG_ZERO=5'd0.
  - stage_ctrl_t struct {stall, flush}, used by all pipeline-register wrappers.
- One natural sub-module: hazard_detect, the purely combinational load-use comparator. All sequencing stays in the top.

Test Plan:
- Load-use: rd_e=5, mem_read_e=1, rs1_d=5, rs1_used_d=1 -> stall_f=stall_d=flush_e=1 for one cycle. Repeat with rd_e=0 -> no stall.
- Redirect with FLUSH_CYCLES=3: redirect_e pulse -> flush_d=1 for 3 cycles and flush_e=1 in the first; a second redirect in cycle 2 -> flush_d for 3 cycles from that point.
- MDU: mdu_start_e=1, mdu_done after 10 cycles -> stall_f/d/e=1 and flush_m=1 for cycles 0..10, released in the mdu_done cycle.
- MDU + memory overlap: mdu_done arrives while dmem_req_m=1 and dmem_ready_m=0 -> MDU stays stalled, done_seen=1; when dmem_ready_m=1, state goes to RUN without a second mdu_done.
- Priority: redirect_e together with a load-use match -> flush_d=flush_e=1, stall_d=0. redirect_e during mw -> only the mw outputs, and the flush appears the cycle mw drops.
- Watchdog with MAX_WAIT=4: hold mw for 6 cycles -> wait_timeout rises at cycle 4 and stays high after mw clears. Asserting reset_n low mid-stall clears all state at once and drives all flushes to 1.
